// File: rtl/cache_pkg.sv
// Shared types and constants for the cache line-fill responder.
package cache_pkg;

  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned IDX_W     = $clog2(BURST_LEN);
  localparam int unsigned CNT_W     = IDX_W + 1;
  localparam int unsigned DATA_W    = 16;

  localparam logic [CNT_W-1:0]  LEN_C    = CNT_W'(BURST_LEN);
  localparam logic [DATA_W-1:0] FILL_PAD = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Burst counters stop at BURST_LEN instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LEN_C) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/cache_burst_responder.sv
// Memory-side responder for the cache line fill: issues 4 word reads, buffers
// the returned words, then streams them to the cache starting with a fill pulse.
module cache_burst_responder
  import cache_pkg::*;
#(
  parameter int unsigned MEM_AW  = 25,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       sdram_addr,
  input  logic              sdram_req,
  input  logic              sdram_rw,
  output logic              sdram_fill,
  output logic [DATA_W-1:0] data_from_sdram,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int unsigned BASE_W = MEM_AW - IDX_W;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   rcvd_q, rcvd_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [TMO_W-1:0]   idle_q, idle_d;
  logic [DATA_W-1:0]  line_q [BURST_LEN];
  logic [DATA_W-1:0]  line_d [BURST_LEN];
  logic               fill_q, fill_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               req_q, req_d;
  logic [MEM_AW-1:0]  addr_q, addr_d;
  logic               err_q, err_d;
  logic               wr_blk_q, wr_blk_d;

  logic               ack_hit_c;
  logic               rv_hit_c;
  logic               unused_addr_c;

  // Bursts are 8-byte aligned, so the top and byte-offset address bits are dropped.
  assign unused_addr_c = ^{sdram_addr[31:MEM_AW+1], sdram_addr[IDX_W:0]};

  assign ack_hit_c = mem_ack & req_q;
  assign rv_hit_c  = mem_rvalid & (outst_q != '0);

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    issued_d = issued_q;
    rcvd_d   = rcvd_q;
    k_d      = k_q;
    idle_d   = idle_q;
    line_d   = line_q;
    fill_d   = 1'b0;
    data_d   = data_q;
    err_d    = 1'b0;
    wr_blk_d = wr_blk_q;
    outst_d  = outst_q + CNT_W'(ack_hit_c) - CNT_W'(rv_hit_c);

    if (mem_rvalid && (outst_q == '0)) begin
      err_d = 1'b1;
    end
    if (!sdram_req) begin
      wr_blk_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (sdram_req && sdram_rw && (outst_q == '0)) begin
          base_d   = sdram_addr[MEM_AW:IDX_W+1];
          issued_d = '0;
          rcvd_d   = '0;
          idle_d   = '0;
          state_d  = BUSY;
        end else if (sdram_req && !sdram_rw && !wr_blk_q) begin
          err_d    = 1'b1;
          wr_blk_d = 1'b1;
        end
      end

      BUSY: begin
        if (ack_hit_c) begin
          issued_d = sat_inc(issued_q);
        end
        if (rv_hit_c && (rcvd_q < LEN_C)) begin
          line_d[rcvd_q[IDX_W-1:0]] = mem_rdata;
          rcvd_d = sat_inc(rcvd_q);
        end
        if (ack_hit_c || mem_rvalid) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + TMO_W'(1);
        end

        if (rcvd_q == LEN_C) begin
          k_d     = '0;
          state_d = STREAM;
        end else if (idle_q == TMO_W'(TIMEOUT)) begin
          // Abandon the burst: pad missing words, keep outstanding for later discard.
          err_d = 1'b1;
          for (int unsigned i = 0; i < BURST_LEN; i++) begin
            if (CNT_W'(i) >= rcvd_q) begin
              line_d[IDX_W'(i)] = FILL_PAD;
            end
          end
          k_d     = '0;
          state_d = STREAM;
        end
      end

      STREAM: begin
        if (k_q < LEN_C) begin
          data_d = line_q[k_q[IDX_W-1:0]];
          fill_d = (k_q == '0);
          k_d    = sat_inc(k_q);
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_d  = (state_d == BUSY) && (issued_d < LEN_C) && (outst_d < CNT_W'(MAX_OUT));
    addr_d = {base_d, issued_d[IDX_W-1:0]};
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      issued_q <= '0;
      rcvd_q   <= '0;
      outst_q  <= '0;
      k_q      <= '0;
      idle_q   <= '0;
      line_q   <= '{default: '0};
      fill_q   <= 1'b0;
      data_q   <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      wr_blk_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      issued_q <= issued_d;
      rcvd_q   <= rcvd_d;
      outst_q  <= outst_d;
      k_q      <= k_d;
      idle_q   <= idle_d;
      line_q   <= line_d;
      fill_q   <= fill_d;
      data_q   <= data_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      wr_blk_q <= wr_blk_d;
    end
  end

  assign sdram_fill      = fill_q;
  assign data_from_sdram = data_q;
  assign mem_req         = req_q;
  assign mem_addr        = addr_q;
  assign err             = err_q;

endmodule

// File: tb/tb_cache_burst_responder.sv
// Directed bench for cache_burst_responder with a behavioural pipelined word memory.
module tb_cache_burst_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] sdram_addr = '0;
  logic        sdram_req = 1'b0;
  logic        sdram_rw = 1'b0;
  logic        sdram_fill;
  logic [15:0] data_from_sdram;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        err;

  cache_burst_responder #(
    .MEM_AW (25),
    .MAX_OUT(4),
    .TIMEOUT(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sdram_addr     (sdram_addr),
    .sdram_req      (sdram_req),
    .sdram_rw       (sdram_rw),
    .sdram_fill     (sdram_fill),
    .data_from_sdram(data_from_sdram),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Memory knobs (written by the stimulus only).
  int          ack_dly = 0;
  int          lat = 3;
  logic [15:0] dbase = 16'hA000;
  int          stall_lim = 0;
  int          spur_req = 0;

  // Memory state (written by the model only).
  int          cyc = 0;
  int          wait_cnt = 0;
  int          ret_cnt = 0;
  int          spur_done = 0;
  int          due_q[$];
  logic [15:0] dat_q[$];
  logic [24:0] addr_log[$];

  // Monitor counters.
  int fill_cnt = 0;
  int err_cnt = 0;
  int reqhi_cnt = 0;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Memory model: decides ack/rvalid on the falling edge for the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      wait_cnt   = 0;
      due_q.delete();
      dat_q.delete();
    end else begin
      if (mem_req && wait_cnt >= ack_dly) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        due_q.push_back(cyc + lat);
        dat_q.push_back(dbase + 16'(mem_addr[1:0]));
        addr_log.push_back(mem_addr);
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = mem_req ? wait_cnt + 1 : 0;
      end
      mem_rvalid = 1'b0;
      if (spur_done < spur_req) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h5555;
        spur_done++;
      end else if (due_q.size() != 0 && due_q[0] <= cyc &&
                   !(stall_lim != 0 && ret_cnt >= stall_lim)) begin
        void'(due_q.pop_front());
        mem_rvalid = 1'b1;
        mem_rdata  = dat_q.pop_front();
        ret_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (sdram_fill === 1'b1) fill_cnt++;
    if (err === 1'b1) err_cnt++;
    if (mem_req === 1'b1) reqhi_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fill(input int budget, output int cycles);
    cycles = 0;
    while (sdram_fill !== 1'b1 && cycles < budget) begin
      step(1);
      cycles++;
    end
  endtask

  // Called on the fill cycle; optionally raises the next request right after word 3.
  task automatic check_burst(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3,
                             input bit chain, input logic [31:0] naddr);
    chk({tag, "_fill"}, 32'(sdram_fill), 32'd1);
    chk({tag, "_w0"}, 32'(data_from_sdram), 32'(d0));
    sdram_req = 1'b0;
    step(1);
    chk({tag, "_w1"}, 32'(data_from_sdram), 32'(d1));
    chk({tag, "_fill_drop"}, 32'(sdram_fill), 32'd0);
    step(1);
    chk({tag, "_w2"}, 32'(data_from_sdram), 32'(d2));
    step(1);
    chk({tag, "_w3"}, 32'(data_from_sdram), 32'(d3));
    if (chain) begin
      sdram_addr = naddr;
      sdram_rw   = 1'b1;
      sdram_req  = 1'b1;
    end
    step(1);
    chk({tag, "_w3_hold"}, 32'(data_from_sdram), 32'(d3));
  endtask

  int cyc_n, lb, fb, eb, rb;

  initial begin
    // Reset state
    step(3);
    chk("rst_fill", 32'(sdram_fill), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_data", 32'(data_from_sdram), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b1;
    step(1);

    // 1: basic burst, 1-cycle ack, latency 3
    lb = addr_log.size(); fb = fill_cnt; eb = err_cnt;
    sdram_addr = 32'h0000_1234; sdram_rw = 1'b1; sdram_req = 1'b1;
    wait_fill(40, cyc_n);
    chk("t1_latency", 32'(cyc_n), 32'd10);
    check_burst("t1", 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1'b0, 32'h0);
    chk("t1_addr0", 32'(addr_log[lb]), 32'h918);
    chk("t1_addr3", 32'(addr_log[lb+3]), 32'h91B);
    chk("t1_fill_once", 32'(fill_cnt - fb), 32'd1);
    chk("t1_no_err", 32'(err_cnt - eb), 32'd0);

    // 2: slow ack (5 cycles) and latency 10
    ack_dly = 5; lat = 10; dbase = 16'hB000;
    lb = addr_log.size(); fb = fill_cnt; eb = err_cnt;
    sdram_addr = 32'h0040_0008; sdram_req = 1'b1;
    wait_fill(200, cyc_n);
    check_burst("t2", 16'hB000, 16'hB001, 16'hB002, 16'hB003, 1'b0, 32'h0);
    chk("t2_addr0", 32'(addr_log[lb]), 32'h200004);
    chk("t2_fill_once", 32'(fill_cnt - fb), 32'd1);
    chk("t2_no_err", 32'(err_cnt - eb), 32'd0);

    // 3: two words return, then memory stalls until timeout
    ack_dly = 0; lat = 3; dbase = 16'hC000;
    stall_lim = ret_cnt + 2;
    fb = fill_cnt; eb = err_cnt;
    sdram_addr = 32'h0000_0100; sdram_req = 1'b1;
    wait_fill(60, cyc_n);
    check_burst("t3", 16'hC000, 16'hC001, 16'hFFFF, 16'hFFFF, 1'b0, 32'h0);
    chk("t3_timeout_err", 32'(err_cnt - eb), 32'd1);
    sdram_addr = 32'h0000_0200; sdram_req = 1'b1;
    step(8);
    chk("t3_blocked_req", 32'(mem_req), 32'd0);
    chk("t3_blocked_fill", 32'(fill_cnt - fb), 32'd1);
    lb = addr_log.size(); dbase = 16'hD000; stall_lim = 0;
    wait_fill(60, cyc_n);
    check_burst("t3b", 16'hD000, 16'hD001, 16'hD002, 16'hD003, 1'b0, 32'h0);
    chk("t3b_addr0", 32'(addr_log[lb]), 32'h100);
    chk("t3_discard_no_err", 32'(err_cnt - eb), 32'd1);

    // 4: write request is rejected with a single err pulse per request
    fb = fill_cnt; eb = err_cnt; rb = reqhi_cnt;
    sdram_addr = 32'h0000_0600; sdram_rw = 1'b0; sdram_req = 1'b1;
    step(5);
    chk("t4_err_once", 32'(err_cnt - eb), 32'd1);
    sdram_req = 1'b0;
    step(2);
    sdram_req = 1'b1;
    step(3);
    chk("t4_err_refire", 32'(err_cnt - eb), 32'd2);
    chk("t4_no_mem_req", 32'(reqhi_cnt - rb), 32'd0);
    chk("t4_no_fill", 32'(fill_cnt - fb), 32'd0);
    sdram_req = 1'b0; sdram_rw = 1'b1;
    step(2);

    // Stray rvalid with nothing outstanding
    eb = err_cnt;
    spur_req++;
    step(3);
    chk("spur_err", 32'(err_cnt - eb), 32'd1);

    // 5: reset during BUSY after two acks
    lat = 8; dbase = 16'hE000;
    lb = addr_log.size(); fb = fill_cnt;
    sdram_addr = 32'h0000_0300; sdram_req = 1'b1;
    for (int i = 0; i < 20 && addr_log.size() < lb + 2; i++) step(1);
    chk("t5_two_acks", 32'(addr_log.size() - lb), 32'd2);
    reset = 1'b0; sdram_req = 1'b0;
    step(1);
    chk("t5_rst_mem_req", 32'(mem_req), 32'd0);
    chk("t5_rst_data", 32'(data_from_sdram), 32'd0);
    step(2);
    reset = 1'b1;
    step(15);
    chk("t5_no_fill", 32'(fill_cnt - fb), 32'd0);
    lat = 3;
    sdram_addr = 32'h0000_0400; sdram_req = 1'b1;
    wait_fill(40, cyc_n);

    // 6: next request raised right after word 3 of the recovery burst
    lb = addr_log.size();
    check_burst("t5", 16'hE000, 16'hE001, 16'hE002, 16'hE003, 1'b1, 32'h0000_0516);
    dbase = 16'hF000;
    wait_fill(40, cyc_n);
    chk("t6_latency", 32'(cyc_n), 32'd10);
    check_burst("t6", 16'hF000, 16'hF001, 16'hF002, 16'hF003, 1'b0, 32'h0);
    chk("t6_addr0", 32'(addr_log[lb]), 32'h288);
    chk("t6_addr3", 32'(addr_log[lb+3]), 32'h28B);
    step(2);
    chk("end_mem_req", 32'(mem_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
